phv_merger: RTL and testbench
=============================

Name: phv_merger

Overview:
- Return path of the action stage: rebuilds the full PHV from the per-container ALU results and the untouched metadata/conditional tail.
- The crossbar issues the tail (phv_remain_data) early.
- 6B, 4B and 2B ALU groups may each complete at a different latency.
- The block buffers the tail, collects the three result groups, concatenates them in PHV order and presents the PHV downstream with a valid/ready handshake.

Parameters:
- STAGE, 0, stage index; informational only.
- WIDTH_6B, 48, 6B container width.
- WIDTH_4B, 32, 4B container width.
- WIDTH_2B, 16, 2B container width.
- REMAIN_LEN, 356, metadata + conditional tail width.
- PHV_LEN, 8*WIDTH_6B+8*WIDTH_4B+8*WIDTH_2B+REMAIN_LEN (1124), full PHV width.
- DEPTH, 4, tail FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_out_6B_valid  in  1  6B group result valid (single-cycle pulse).
- alu_out_6B  in  8*WIDTH_6B  container i at [(i+1)*48-1 -: 48].
- alu_out_4B_valid  in  1  4B group result valid.
- alu_out_4B  in  8*WIDTH_4B  container i at [(i+1)*32-1 -: 32].
- alu_out_2B_valid  in  1  2B group result valid.
- alu_out_2B  in  8*WIDTH_2B  container i at [(i+1)*16-1 -: 16].
- phv_remain_valid  in  1  tail valid.
- phv_remain_data  in  REMAIN_LEN  tail bits, PHV[355:0].
- phv_out  out  PHV_LEN  rebuilt PHV.
- phv_out_valid  out  1  phv_out valid.
- phv_out_ready  in  1  downstream accept.
- err_overflow  out  1  sticky; data dropped.
- remain_count  out  $clog2(DEPTH)+1  tail FIFO occupancy.

Behaviour:
- Output layout:
  - phv_out[1123:740] = alu_out_6B
  - phv_out[739:484] = alu_out_4B
  - phv_out[483:356] = alu_out_2B
  - phv_out[355:0] = tail
  - Container 7 of each group sits at the MSB.
- Reset: phv_out=0, phv_out_valid=0, err_overflow=0, remain_count=0. All group-held flags are cleared and the FIFO is emptied. A reset mid-operation discards partial groups and buffered tails; no PHV is emitted for them.
- Group capture: on a rising edge with alu_out_xB_valid=1, the data loads into hold register xB and have_xB is set.
  - If have_xB is already set and not being consumed that edge, the new data is dropped, the held data is kept, and err_overflow is set.
- Tail FIFO:
  - Pushes on phv_remain_valid and pops on assemble.
  - No bypass: a tail is poppable at the earliest one edge after its push.
  - Push when full is dropped and sets err_overflow, unless a pop occurs on the same edge (push and pop both happen).
  - Pop when empty cannot occur, because assemble requires a non-empty FIFO.
- Assemble condition: have_6B & have_4B & have_2B & fifo_nonempty & (!phv_out_valid | phv_out_ready).
- Assemble action, on the rising edge:
  - phv_out <= concat(hold_6B, hold_4B, hold_2B, fifo_head); phv_out_valid <= 1.
  - Clear all three have flags and pop the FIFO.
  - A group valid on that same edge re-fills its hold register and leaves its flag set.
  - Sustained throughput is one PHV per cycle.
- Handshake:
  - phv_out_valid=1 & phv_out_ready=1 with no new assemble → phv_out_valid <= 0; phv_out retains its value.
  - While phv_out_valid=1 & phv_out_ready=0, phv_out is stable.
- Latency: minimum is 2 rising edges from sampling the last required input to phv_out_valid=1.
- Ordering: strictly in order. The n-th group triple pairs with the n-th tail.
- err_overflow is cleared only by reset.
- remain_count reflects occupancy after each edge.
- Internal state per group:
  - EMPTY→HELD on valid.
  - HELD→EMPTY on assemble without a new valid.
  - HELD→HELD on assemble with a new valid, or on a dropped valid.

Decomposition:
- Shared package (rmt_pkg):
  - WIDTH_6B/4B/2B, REMAIN_LEN, PHV_LEN.
  - Container count 8.
  - Field offsets OFF_6B=740, OFF_4B=484, OFF_2B=356.
- One sub-module: remain_fifo.
  - Synchronous FIFO with parameters WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async reset on pointers only.

Test Plan:
- Single PHV, ready=1: one cycle with all four valids, 6B=0x0101..., 4B=0x0202..., 2B=0x0303..., tail=0x0404... → phv_out_valid high for one cycle, 2 edges later, with phv_out exactly that concatenation.
- Staggered arrival: tail at cycle 0, 6B at 3, 2B at 5, 4B at 7 → phv_out_valid rises at edge 9 with correct fields; nothing is emitted earlier.
- Backpressure: ready=0 for 5 cycles, second PHV inputs arrive during the stall → first phv_out held unchanged. Second PHV appears the cycle after first accept; order is preserved; err_overflow=0.
- Overflow, DEPTH=4: 5 tail pushes with no results → remain_count=4, err_overflow=1. Then 6B valid twice → first 6B value kept.
- Back-to-back: 3 full PHVs on consecutive cycles, ready=1 → 3 consecutive phv_out_valid cycles in order.
- Reset mid-operation: tail plus 6B only, then rst_n low for 2 cycles → all outputs 0. A subsequent full PHV emits only the new data.

Source files
------------

// File: rtl/rmt_pkg.sv
// Shared widths, field offsets and types for the match-action stage datapath.
// Both the action-stage return path and its testbench take their constants from here.
package rmt_pkg;

    localparam int unsigned WIDTH_6B   = 48;
    localparam int unsigned WIDTH_4B   = 32;
    localparam int unsigned WIDTH_2B   = 16;
    localparam int unsigned REMAIN_LEN = 356;
    localparam int unsigned N_CONT     = 8;

    localparam int unsigned PHV_LEN = N_CONT * (WIDTH_6B + WIDTH_4B + WIDTH_2B) + REMAIN_LEN;

    // Each ALU group lands above the previous one; the tail sits at bit 0.
    localparam int unsigned OFF_2B = REMAIN_LEN;
    localparam int unsigned OFF_4B = OFF_2B + N_CONT * WIDTH_2B;
    localparam int unsigned OFF_6B = OFF_4B + N_CONT * WIDTH_4B;

    localparam int unsigned N_GRP = 3;

    typedef enum logic {
        GRP_EMPTY = 1'b0,
        GRP_HELD  = 1'b1
    } grp_state_t;

endpackage

// File: rtl/remain_fifo.sv
// Synchronous FIFO for PHV tails. The head is read straight from storage,
// so an entry becomes visible one edge after it is written.
module remain_fifo #(
    parameter int unsigned WIDTH = 356,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign count = r_wr_ptr - r_rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/phv_merger.sv
// Action-stage return path: holds the three ALU result groups and the early tail,
// then emits the rebuilt PHV in order over a valid/ready handshake.
module phv_merger #(
    parameter int          STAGE      = 0,
    parameter int unsigned WIDTH_6B   = rmt_pkg::WIDTH_6B,
    parameter int unsigned WIDTH_4B   = rmt_pkg::WIDTH_4B,
    parameter int unsigned WIDTH_2B   = rmt_pkg::WIDTH_2B,
    parameter int unsigned REMAIN_LEN = rmt_pkg::REMAIN_LEN,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PHV_LEN   = rmt_pkg::N_CONT * (WIDTH_6B + WIDTH_4B + WIDTH_2B) + REMAIN_LEN,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_out_6B_valid,
    input  logic [8*WIDTH_6B-1:0] alu_out_6B,
    input  logic                  alu_out_4B_valid,
    input  logic [8*WIDTH_4B-1:0] alu_out_4B,
    input  logic                  alu_out_2B_valid,
    input  logic [8*WIDTH_2B-1:0] alu_out_2B,
    input  logic                  phv_remain_valid,
    input  logic [REMAIN_LEN-1:0] phv_remain_data,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic                  phv_out_valid,
    input  logic                  phv_out_ready,
    output logic                  err_overflow,
    output logic [CNT_W-1:0]      remain_count
);

    import rmt_pkg::*;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("phv_merger: DEPTH must be a power of two and at least 2");
    end
    if (STAGE < 0) begin : g_bad_stage
        $error("phv_merger: STAGE must be non-negative");
    end

    grp_state_t r_state [N_GRP];
    grp_state_t w_state_nxt [N_GRP];

    logic [8*WIDTH_6B-1:0] r_hold_6B;
    logic [8*WIDTH_4B-1:0] r_hold_4B;
    logic [8*WIDTH_2B-1:0] r_hold_2B;
    logic [N_GRP-1:0]      w_grp_valid;
    logic [N_GRP-1:0]      w_have;
    logic [N_GRP-1:0]      w_load;
    logic [N_GRP-1:0]      w_drop;

    logic [REMAIN_LEN-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_tail_drop;
    logic                  w_assemble;

    assign w_grp_valid = {alu_out_2B_valid, alu_out_4B_valid, alu_out_6B_valid};

    for (genvar g = 0; g < N_GRP; g++) begin : g_have
        assign w_have[g] = (r_state[g] == GRP_HELD);
    end

    assign w_assemble = (&w_have) && !w_empty && (!phv_out_valid || phv_out_ready);

    // A full FIFO still takes the new tail when the head leaves on the same edge.
    assign w_push      = phv_remain_valid && (!w_full || w_assemble);
    assign w_tail_drop = phv_remain_valid && w_full && !w_assemble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < N_GRP; g++) r_state[g] <= GRP_EMPTY;
        end else begin
            for (int g = 0; g < N_GRP; g++) r_state[g] <= w_state_nxt[g];
        end
    end

    always_comb begin
        for (int g = 0; g < N_GRP; g++) begin
            w_state_nxt[g] = r_state[g];
            case (r_state[g])
                GRP_EMPTY: if (w_grp_valid[g]) w_state_nxt[g] = GRP_HELD;
                GRP_HELD:  if (w_assemble && !w_grp_valid[g]) w_state_nxt[g] = GRP_EMPTY;
                default:   w_state_nxt[g] = GRP_EMPTY;
            endcase
        end
    end

    always_comb begin
        for (int g = 0; g < N_GRP; g++) begin
            w_load[g] = w_grp_valid[g] && (!w_have[g] || w_assemble);
            w_drop[g] = w_grp_valid[g] && w_have[g] && !w_assemble;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load[0]) r_hold_6B <= alu_out_6B;
        if (w_load[1]) r_hold_4B <= alu_out_4B;
        if (w_load[2]) r_hold_2B <= alu_out_2B;
    end

    remain_fifo #(
        .WIDTH (REMAIN_LEN),
        .DEPTH (DEPTH)
    ) u_remain_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_assemble),
        .din   (phv_remain_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (remain_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_out       <= '0;
            phv_out_valid <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (w_assemble) begin
                phv_out       <= {r_hold_6B, r_hold_4B, r_hold_2B, w_head};
                phv_out_valid <= 1'b1;
            end else if (phv_out_ready) begin
                phv_out_valid <= 1'b0;
            end
            if (w_tail_drop || (|w_drop)) err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phv_merger.sv
// Directed bench for phv_merger: a queue of expected PHVs built from the field
// layout is checked against every accepted output, plus literal timing/field checks.
module tb_phv_merger;

    import rmt_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v6 = 1'b0, v4 = 1'b0, v2 = 1'b0, vt = 1'b0;
    logic [383:0]  d6 = '0;
    logic [255:0]  d4 = '0;
    logic [127:0]  d2 = '0;
    logic [355:0]  dt = '0;
    logic [1123:0] phv_out;
    logic          phv_out_valid;
    logic          phv_out_ready = 1'b1;
    logic          err_overflow;
    logic [2:0]    remain_count;

    int n_total = 0;
    int n_bad   = 0;
    logic          exp_err = 1'b0;
    logic [1123:0] exp_q [$];

    phv_merger u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alu_out_6B_valid (v6),
        .alu_out_6B       (d6),
        .alu_out_4B_valid (v4),
        .alu_out_4B       (d4),
        .alu_out_2B_valid (v2),
        .alu_out_2B       (d2),
        .phv_remain_valid (vt),
        .phv_remain_data  (dt),
        .phv_out          (phv_out),
        .phv_out_valid    (phv_out_valid),
        .phv_out_ready    (phv_out_ready),
        .err_overflow     (err_overflow),
        .remain_count     (remain_count)
    );

    always #5 clk = ~clk;

    function automatic logic [383:0] rep6(input logic [7:0] b);
        return {48{b}};
    endfunction
    function automatic logic [255:0] rep4(input logic [7:0] b);
        return {32{b}};
    endfunction
    function automatic logic [127:0] rep2(input logic [7:0] b);
        return {16{b}};
    endfunction
    function automatic logic [355:0] rept(input logic [7:0] b);
        logic [359:0] t;
        t = {45{b}};
        return t[355:0];
    endfunction

    // Model: the rebuilt PHV is the three groups followed by the tail, MSB first.
    function automatic logic [1123:0] model_phv(input logic [7:0] b6, b4, b2, bt);
        logic [1123:0] p;
        p = '0;
        p[OFF_6B +: 384]     = rep6(b6);
        p[OFF_4B +: 256]     = rep4(b4);
        p[OFF_2B +: 128]     = rep2(b2);
        p[0 +: REMAIN_LEN]   = rept(bt);
        return p;
    endfunction

    function automatic logic [63:0] fold(input logic [1123:0] p);
        logic [1151:0] x;
        logic [63:0]   f;
        x = {28'h0, p};
        f = '0;
        for (int i = 0; i < 18; i++) f ^= x[i*64 +: 64];
        return f;
    endfunction

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [1123:0] got, input logic [1123:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got fold %h low %h, expected fold %h low %h",
                     name, fold(got), got[63:0], fold(exp), exp[63:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s6, input logic [7:0] b6, input logic s4, input logic [7:0] b4,
                        input logic s2, input logic [7:0] b2, input logic st, input logic [7:0] bt);
        v6 = s6; d6 = rep6(b6);
        v4 = s4; d4 = rep4(b4);
        v2 = s2; d2 = rep2(b2);
        vt = st; dt = rept(bt);
        cyc();
        v6 = 1'b0; v4 = 1'b0; v2 = 1'b0; vt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        exp_err = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        check1("rst_valid", phv_out_valid, 0);
        check1("rst_err", err_overflow, 0);
        check1("rst_count", remain_count, 0);
        check_w("rst_phv", phv_out, '0);
        rst_n = 1'b1;
        cyc();
    endtask

    // Compare process: in-order accepted PHVs, stability under stall, sticky error flag.
    logic          prev_stall = 1'b0;
    logic [1123:0] prev_out = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check1("stall_valid", phv_out_valid, 1);
                check_w("stall_data", phv_out, prev_out);
            end
            if (phv_out_valid && phv_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_phv: got fold %h, expected no output", fold(phv_out));
                end else begin
                    check_w("phv_order", phv_out, exp_q.pop_front());
                end
            end
            check1("err_overflow", err_overflow, exp_err);
        end
        prev_stall = rst_n && phv_out_valid && !phv_out_ready;
        prev_out   = phv_out;
    end

    initial begin
        do_reset();

        // Single PHV, all inputs in one cycle.
        exp_q.push_back(model_phv(8'h01, 8'h02, 8'h03, 8'h04));
        send(1, 8'h01, 1, 8'h02, 1, 8'h03, 1, 8'h04);
        check1("single_e1_valid", phv_out_valid, 0);
        cyc();
        check1("single_e2_valid", phv_out_valid, 1);
        check1("single_6B_msb", phv_out[1123:1116], 8'h01);
        check1("single_4B_msb", phv_out[739:732], 8'h02);
        check1("single_2B_lsb", phv_out[359:356], 4'h3);
        check1("single_tail_msb", phv_out[355:352], 4'h4);
        check1("single_tail_lsb", phv_out[7:0], 8'h04);
        cyc();
        check1("single_e3_valid", phv_out_valid, 0);

        // Staggered arrival: tail c0, 6B c3, 2B c5, 4B c7 -> valid only after edge 9.
        exp_q.push_back(model_phv(8'h11, 8'h12, 8'h13, 8'h14));
        for (int c = 0; c < 9; c++) begin
            send(c == 3, 8'h11, c == 7, 8'h12, c == 5, 8'h13, c == 0, 8'h14);
            check1($sformatf("stag_valid_e%0d", c + 1), phv_out_valid, (c == 8) ? 1 : 0);
            if (c == 0) check1("stag_count_e1", remain_count, 1);
        end
        check1("stag_count_e9", remain_count, 0);
        cyc();

        // Backpressure: five stalled cycles, second PHV arrives during the stall.
        phv_out_ready = 1'b0;
        exp_q.push_back(model_phv(8'h21, 8'h22, 8'h23, 8'h24));
        exp_q.push_back(model_phv(8'h31, 8'h32, 8'h33, 8'h34));
        send(1, 8'h21, 1, 8'h22, 1, 8'h23, 1, 8'h24);
        cyc();
        check1("bp_first_valid", phv_out_valid, 1);
        send(1, 8'h31, 1, 8'h32, 1, 8'h33, 1, 8'h34);
        cyc();
        cyc();
        cyc();
        check1("bp_held_tail", phv_out[7:0], 8'h24);
        check1("bp_count", remain_count, 1);
        phv_out_ready = 1'b1;
        cyc();
        check1("bp_second_valid", phv_out_valid, 1);
        check1("bp_second_tail", phv_out[7:0], 8'h34);
        cyc();
        check1("bp_drained", phv_out_valid, 0);
        check1("bp_no_err", err_overflow, 0);

        // Back-to-back: three PHVs on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model_phv(8'h41 + 8'(k), 8'h51 + 8'(k), 8'h61 + 8'(k), 8'h71 + 8'(k)));
        end
        for (int k = 0; k < 3; k++) begin
            send(1, 8'h41 + 8'(k), 1, 8'h51 + 8'(k), 1, 8'h61 + 8'(k), 1, 8'h71 + 8'(k));
            check1($sformatf("b2b_valid_e%0d", k + 1), phv_out_valid, (k > 0) ? 1 : 0);
        end
        cyc();
        check1("b2b_valid_e4", phv_out_valid, 1);
        cyc();
        check1("b2b_valid_e5", phv_out_valid, 0);

        // Reset mid-operation discards the partial PHV.
        send(1, 8'hA1, 0, 8'h00, 0, 8'h00, 1, 8'hA4);
        check1("mid_count", remain_count, 1);
        do_reset();
        exp_q.push_back(model_phv(8'hB1, 8'hB2, 8'hB3, 8'hB4));
        send(1, 8'hB1, 1, 8'hB2, 1, 8'hB3, 1, 8'hB4);
        cyc();
        check1("post_rst_valid", phv_out_valid, 1);
        check1("post_rst_6B", phv_out[1123:1116], 8'hB1);
        cyc();
        cyc();

        // Overflow: five tails into a four-entry FIFO, then a doubled 6B result.
        for (int k = 0; k < 5; k++) begin
            send(0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'hC1 + 8'(k));
            if (k == 4) exp_err = 1'b1;
            check1($sformatf("ovf_count_%0d", k), remain_count, (k < 4) ? k + 1 : 4);
            check1($sformatf("ovf_err_%0d", k), err_overflow, (k == 4) ? 1 : 0);
        end
        exp_q.push_back(model_phv(8'hD1, 8'hD3, 8'hD4, 8'hC1));
        send(1, 8'hD1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        send(1, 8'hD2, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        send(0, 8'h00, 1, 8'hD3, 1, 8'hD4, 0, 8'h00);
        cyc();
        check1("ovf_first_6B_kept", phv_out[1123:1116], 8'hD1);
        check1("ovf_head_tail", phv_out[7:0], 8'hC1);
        cyc();
        check1("ovf_count_after", remain_count, 3);
        check1("ovf_err_sticky", err_overflow, 1);
        cyc();

        check1("exp_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
